execute_mc: RTL

Parametrised multi-cycle execute stage for the Y86 pipeline. Contents:
- XLEN-wide ALU and the ZF/SF/OF condition-code register.
- Condition evaluation for cmovXX/jXX, with `e_dstE_o` gating.
- New `mulq` operation (OPq, ifun 4), computed by an iterative shift-add multiplier.

The block sits between the E and M pipeline registers. While a multiply is in flight it raises `e_stall_o` so pipeline control holds F/D/E and bubbles M.

---
 rtl/y86_pkg.sv | 41 ++++
 rtl/execute_mc_if.sv | 31 +++
 rtl/exec_mul_iter.sv | 93 +++++++++
 rtl/execute_mc.sv | 129 ++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 encodings: instruction/function codes, condition codes, status
// codes and the multiplier FSM state type.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALUADD = 4'h0;
  localparam logic [3:0] ALUSUB = 4'h1;
  localparam logic [3:0] ALUAND = 4'h2;
  localparam logic [3:0] ALUXOR = 4'h3;
  localparam logic [3:0] ALUMUL = 4'h4;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SADR = 4'h2;
  localparam logic [3:0] SINS = 4'h3;
  localparam logic [3:0] SHLT = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

endpackage

// File: rtl/execute_mc_if.sv
// E-register inputs and execute-stage outputs of the Y86 execute stage.
// master = pipeline side, slave = execute_mc.
interface execute_mc_if #(
  parameter int XLEN = 64
);
  logic [3:0]      E_icode_i;
  logic [3:0]      E_ifun_i;
  logic [XLEN-1:0] E_valC_i;
  logic [XLEN-1:0] E_valA_i;
  logic [XLEN-1:0] E_valB_i;
  logic [3:0]      E_dstE_i;
  logic [3:0]      m_stat_i;
  logic [3:0]      W_stat_i;
  logic            flush_i;
  logic            e_Cnd_o;
  logic [3:0]      e_dstE_o;
  logic [XLEN-1:0] e_valE_o;
  logic            e_stall_o;

  modport master (
    output E_icode_i, E_ifun_i, E_valC_i, E_valA_i, E_valB_i, E_dstE_i,
           m_stat_i, W_stat_i, flush_i,
    input  e_Cnd_o, e_dstE_o, e_valE_o, e_stall_o
  );

  modport slave (
    input  E_icode_i, E_ifun_i, E_valC_i, E_valA_i, E_valB_i, E_dstE_i,
           m_stat_i, W_stat_i, flush_i,
    output e_Cnd_o, e_dstE_o, e_valE_o, e_stall_o
  );
endinterface

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_R multiplier bits per cycle.
// EXEC_MUL_EARLY_EN: leave RUN once the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting; a start latches operands and stalls
// RUN   | one shift-add step per cycle, stall held
// DONE  | product valid for one cycle, stall released
module exec_mul_iter
  import y86_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int MUL_R = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);
  localparam int STEPS = XLEN / MUL_R;
  localparam int CW    = $clog2(STEPS + 1);

  mul_state_t      state_q, state_d;
  logic [XLEN-1:0] mcand_q, mplier_q, acc_q;
  logic [XLEN-1:0] partial, mplier_nxt;
  logic [CW-1:0]   count_q;
  logic            last_step;

  assign partial    = mcand_q * XLEN'(mplier_q[MUL_R-1:0]);
  assign mplier_nxt = mplier_q >> MUL_R;
  assign product    = acc_q;

`ifdef EXEC_MUL_EARLY_EN
  assign last_step = (count_q == '0) || (mplier_nxt == '0);
`else
  assign last_step = (count_q == '0);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start && !flush) begin
        mcand_q  <= op_b;
        mplier_q <= op_a;
        acc_q    <= '0;
        count_q  <= CW'(STEPS - 1);
      end else if (state_q == RUN && !flush) begin
        acc_q    <= acc_q + partial;
        mcand_q  <= mcand_q << MUL_R;
        mplier_q <= mplier_nxt;
        if (count_q != '0) count_q <= count_q - CW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        busy    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // stall must fall in the same cycle as a flush or an asserted reset
    if (flush || rst_i) begin
      state_d = IDLE;
      busy    = 1'b0;
      done    = 1'b0;
    end
  end

endmodule

// File: rtl/execute_mc.sv
// Y86 multi-cycle execute stage: operand muxes, ALU, ZF/SF/OF register,
// condition evaluation and iterative mulq (EXEC_MUL_EARLY_EN enables early exit).
module execute_mc
  import y86_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int MUL_R = 1
) (
  input logic         clk_i,
  input logic         rst_i,
  execute_mc_if.slave ex
);
  localparam logic [XLEN-1:0] EIGHT = XLEN'(8);
  localparam int MSB = XLEN - 1;

  logic [XLEN-1:0] alu_a, alu_b, alu_sum, alu_diff, alu_res, mul_prod;
  logic [3:0]      alu_fun;
  logic            is_opq, is_mul, mul_busy, mul_done;
  logic            set_cc, cnd, of_n, lt;
  logic            zf_q, sf_q, of_q;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (ex.E_icode_i)
      I_RRMOVQ: alu_a = ex.E_valA_i;
      I_IRMOVQ: alu_a = ex.E_valC_i;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = ex.E_valC_i;
        alu_b = ex.E_valB_i;
      end
      I_OPQ: begin
        alu_a = ex.E_valA_i;
        alu_b = ex.E_valB_i;
      end
      I_PUSHQ, I_CALL: begin
        alu_a = '0 - EIGHT;
        alu_b = ex.E_valB_i;
      end
      I_POPQ, I_RET: begin
        alu_a = EIGHT;
        alu_b = ex.E_valB_i;
      end
      default: ;
    endcase
  end

  assign is_opq   = (ex.E_icode_i == I_OPQ);
  assign alu_fun  = is_opq ? ex.E_ifun_i : ALUADD;
  assign is_mul   = is_opq && (ex.E_ifun_i == ALUMUL);
  assign alu_sum  = alu_b + alu_a;
  assign alu_diff = alu_b - alu_a;

  exec_mul_iter #(.XLEN(XLEN), .MUL_R(MUL_R)) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (is_mul),
    .flush   (ex.flush_i),
    .op_a    (ex.E_valA_i),
    .op_b    (ex.E_valB_i),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // undefined function codes fall through to ADD, including its OF rule
  always_comb begin
    alu_res = alu_sum;
    of_n    = (alu_a[MSB] == alu_b[MSB]) && (alu_b[MSB] != alu_sum[MSB]);
    case (alu_fun)
      ALUSUB: begin
        alu_res = alu_diff;
        of_n    = (alu_a[MSB] != alu_b[MSB]) && (alu_b[MSB] != alu_diff[MSB]);
      end
      ALUAND: begin
        alu_res = alu_b & alu_a;
        of_n    = 1'b0;
      end
      ALUXOR: begin
        alu_res = alu_b ^ alu_a;
        of_n    = 1'b0;
      end
      ALUMUL: begin
        alu_res = mul_done ? mul_prod : '0;
        of_n    = 1'b0;
      end
      default: ;
    endcase
  end

  assign set_cc = is_opq && (ex.m_stat_i == SAOK) && (ex.W_stat_i == SAOK) &&
                  (!is_mul || mul_done) && !ex.flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (set_cc) begin
      zf_q <= (alu_res == '0);
      sf_q <= alu_res[MSB];
      of_q <= of_n;
    end
  end

  assign lt = sf_q ^ of_q;

  always_comb begin
    cnd = 1'b1;
    if (ex.E_icode_i == I_RRMOVQ || ex.E_icode_i == I_JXX) begin
      case (ex.E_ifun_i)
        C_YES:   cnd = 1'b1;
        C_LE:    cnd = lt | zf_q;
        C_L:     cnd = lt;
        C_E:     cnd = zf_q;
        C_NE:    cnd = !zf_q;
        C_GE:    cnd = !lt;
        C_G:     cnd = !lt && !zf_q;
        default: cnd = 1'b0;
      endcase
    end
  end

  assign ex.e_Cnd_o   = cnd;
  assign ex.e_stall_o = mul_busy;
  assign ex.e_valE_o  = mul_busy ? '0 : alu_res;
  assign ex.e_dstE_o  = (cnd && !mul_busy) ? ex.E_dstE_i : RNONE;

endmodule
